// File: rtl/add_serial_param.sv
// Digit-serial adder/subtractor: WIDTH-bit operands, DIGIT bits per cycle, LSB-first.
// Define ADD_SERIAL_OVF_EN to build the signed-overflow flag; otherwise ovf is tied to 0.
module add_serial_param #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = $clog2(N) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               start;
  logic               last;
  logic [DIGIT:0]     digit_sum;
  logic [WIDTH+DIGIT-1:0] out_shift;

  assign start = en && ((state_q == IDLE) || (state_q == DONE));
  assign last  = (state_q == ADD) && (count_q == LAST);

  // One digit of the ripple: DIGIT bits plus the carry, kept DIGIT+1 wide.
  assign digit_sum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                   + {{DIGIT{1'b0}}, carry_q};
  // New digit enters at the top; the concat keeps DIGIT == WIDTH legal.
  assign out_shift = {digit_sum[DIGIT-1:0], out_q};

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      carry_q <= 1'b0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
      carry_q <= carry_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = en ? ADD : IDLE;
      ADD:     state_d = last ? DONE : ADD;
      DONE:    state_d = en ? ADD : DONE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture on start, shift one digit per ADD cycle, hold otherwise.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    out_d   = out_q;
    carry_d = carry_q;
    count_d = count_q;
    if (start) begin
      a_d     = a;
      b_d     = sub ? ~b : b;
      carry_d = sub;
      count_d = '0;
      out_d   = '0;
    end else if (state_q == ADD) begin
      a_d     = a_q >> DIGIT;
      b_d     = b_q >> DIGIT;
      carry_d = digit_sum[DIGIT];
      count_d = count_q + CNT_W'(1);
      out_d   = out_shift[WIDTH+DIGIT-1:DIGIT];
    end
  end

  // Output logic: flags are registered from the next state.
  always_comb begin
    busy_d = (state_d == ADD);
    done_d = (state_d == DONE);
  end

  assign out  = out_q;
  assign cout = carry_q;
  assign busy = busy_q;
  assign done = done_q;

`ifdef ADD_SERIAL_OVF_EN
  logic ovf_q, ovf_d;

  // MSBs of the final digit; b_q already holds the inverted operand when subtracting.
  always_comb begin
    ovf_d = ovf_q;
    if (start) begin
      ovf_d = 1'b0;
    end else if (last) begin
      ovf_d = (a_q[DIGIT-1] == b_q[DIGIT-1]) && (digit_sum[DIGIT-1] != a_q[DIGIT-1]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_add_serial_param.sv
// Scoreboard bench for add_serial_param: three instances (8/1, 16/4, 8/2) driven by directed vectors.
`timescale 1ns/1ps
module tb_add_serial_param;

`ifdef ADD_SERIAL_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  typedef struct {
    logic [15:0] out;
    logic        cout;
    logic        ovf;
    int          start_cyc;
    int          n;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance 0: WIDTH=8 DIGIT=1
  logic        en0 = 0, sub0 = 0;
  logic [7:0]  a0 = 0, b0 = 0, out0;
  logic        cout0, ovf0, busy0, done0;
  // Instance 1: WIDTH=16 DIGIT=4
  logic        en1 = 0, sub1 = 0;
  logic [15:0] a1 = 0, b1 = 0, out1;
  logic        cout1, ovf1, busy1, done1;
  // Instance 2: WIDTH=8 DIGIT=2
  logic        en2 = 0, sub2 = 0;
  logic [7:0]  a2 = 0, b2 = 0, out2;
  logic        cout2, ovf2, busy2, done2;

  add_serial_param #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
    .clk(clk), .rst(rst), .en(en0), .sub(sub0), .a(a0), .b(b0),
    .out(out0), .cout(cout0), .ovf(ovf0), .busy(busy0), .done(done0)
  );
  add_serial_param #(.WIDTH(16), .DIGIT(4)) u_w16d4 (
    .clk(clk), .rst(rst), .en(en1), .sub(sub1), .a(a1), .b(b1),
    .out(out1), .cout(cout1), .ovf(ovf1), .busy(busy1), .done(done1)
  );
  add_serial_param #(.WIDTH(8), .DIGIT(2)) u_w8d2 (
    .clk(clk), .rst(rst), .en(en2), .sub(sub2), .a(a2), .b(b2),
    .out(out2), .cout(cout2), .ovf(ovf2), .busy(busy2), .done(done2)
  );

  logic [15:0] m_out [3];
  logic        m_cout[3], m_ovf[3], m_busy[3], m_done[3];
  assign m_out[0] = {8'h00, out0};
  assign m_out[1] = out1;
  assign m_out[2] = {8'h00, out2};
  assign m_cout[0] = cout0; assign m_cout[1] = cout1; assign m_cout[2] = cout2;
  assign m_ovf[0]  = ovf0;  assign m_ovf[1]  = ovf1;  assign m_ovf[2]  = ovf2;
  assign m_busy[0] = busy0; assign m_busy[1] = busy1; assign m_busy[2] = busy2;
  assign m_done[0] = done0; assign m_done[1] = done1; assign m_done[2] = done2;

  exp_t sb0[$];
  exp_t sb1[$];
  exp_t sb2[$];

  int n_cmp = 0;
  int n_bad = 0;
  int busy_cnt[3];
  logic prev_done[3];

  function automatic int n_of(input int idx);
    return (idx == 0) ? 8 : 4;
  endfunction

  function automatic int q_size(input int idx);
    case (idx)
      0:       return sb0.size();
      1:       return sb1.size();
      default: return sb2.size();
    endcase
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic check_done(input int idx);
    exp_t e;
    bit   got;
    got = 1'b0;
    case (idx)
      0: if (sb0.size() > 0) begin e = sb0.pop_front(); got = 1'b1; end
      1: if (sb1.size() > 0) begin e = sb1.pop_front(); got = 1'b1; end
      default: if (sb2.size() > 0) begin e = sb2.pop_front(); got = 1'b1; end
    endcase
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_done inst%0d: got done=1, required no done (nothing issued)", idx);
    end else begin
      $display("inst%0d done: out=%h cout=%b ovf=%b cycles=%0d busy=%0d", idx,
               m_out[idx], m_cout[idx], m_ovf[idx], cyc - e.start_cyc, busy_cnt[idx]);
      cmp($sformatf("out inst%0d", idx), 32'(m_out[idx]), 32'(e.out));
      cmp($sformatf("cout inst%0d", idx), 32'(m_cout[idx]), 32'(e.cout));
      cmp($sformatf("ovf inst%0d", idx), 32'(m_ovf[idx]), 32'(e.ovf));
      // done appears N edges after the start edge (N+1 edges counting the start edge)
      cmp($sformatf("latency inst%0d", idx), 32'(cyc - e.start_cyc), 32'(e.n));
      cmp($sformatf("busy_cycles inst%0d", idx), 32'(busy_cnt[idx]), 32'(e.n));
    end
    busy_cnt[idx] = 0;
  endtask

  // Monitor: samples on the falling edge, checks each rising done against the scoreboard.
  initial begin
    for (int i = 0; i < 3; i++) begin
      busy_cnt[i]  = 0;
      prev_done[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (!rst) begin
          busy_cnt[i]  = 0;
          prev_done[i] = 1'b0;
        end else begin
          if (m_busy[i] === 1'b1) busy_cnt[i]++;
          if (m_done[i] === 1'b1 && !prev_done[i]) check_done(i);
          prev_done[i] = (m_done[i] === 1'b1);
        end
      end
    end
  end

  task automatic issue(input int idx, input logic [15:0] av, input logic [15:0] bv,
                       input logic sv, input bit push, input logic [15:0] eo,
                       input logic ec, input logic eov);
    exp_t e;
    case (idx)
      0: begin en0 = 1; a0 = av[7:0]; b0 = bv[7:0]; sub0 = sv; end
      1: begin en1 = 1; a1 = av;      b1 = bv;      sub1 = sv; end
      default: begin en2 = 1; a2 = av[7:0]; b2 = bv[7:0]; sub2 = sv; end
    endcase
    @(posedge clk);
    #1;
    case (idx)
      0: en0 = 0;
      1: en1 = 0;
      default: en2 = 0;
    endcase
    if (push) begin
      e = '{out: eo, cout: ec, ovf: eov, start_cyc: cyc, n: n_of(idx)};
      case (idx)
        0: sb0.push_back(e);
        1: sb1.push_back(e);
        default: sb2.push_back(e);
      endcase
    end
  endtask

  task automatic wait_idle(input int idx);
    int k;
    k = 0;
    while (q_size(idx) != 0 && k < 100) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (q_size(idx) != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout inst%0d: got %0d results outstanding, required 0", idx, q_size(idx));
      case (idx)
        0: sb0.delete();
        1: sb1.delete();
        default: sb2.delete();
      endcase
    end
  endtask

  initial begin
    exp_t e;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    cmp("reset_state inst0", 32'({out0, cout0, ovf0, busy0, done0}), 32'h0);
    cmp("reset_state inst1", 32'({out1, cout1, ovf1, busy1, done1}), 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Reset mid-ADD: start 55+0F, pull reset three edges later, result must vanish
    issue(0, 16'h0055, 16'h000F, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    cmp("busy_after_start inst0", 32'(busy0), 32'h1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    cmp("abort_outputs inst0", 32'({out0, cout0, ovf0, busy0, done0}), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    cmp("no_done_after_abort inst0", 32'({busy0, done0}), 32'h0);

    // WIDTH=8 DIGIT=1 vectors
    issue(0, 16'h00FF, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    wait_idle(0);
    issue(0, 16'h0005, 16'h0007, 1'b1, 1'b1, 16'h00FE, 1'b0, 1'b0);
    wait_idle(0);
    issue(0, 16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);
    wait_idle(0);
    issue(0, 16'h007F, 16'h0001, 1'b0, 1'b1, 16'h0080, 1'b0, OVF_ON);
    wait_idle(0);
    issue(0, 16'h0080, 16'h0001, 1'b1, 1'b1, 16'h007F, 1'b1, OVF_ON);
    wait_idle(0);
    issue(0, 16'h0010, 16'h0010, 1'b0, 1'b1, 16'h0020, 1'b0, 1'b0);
    wait_idle(0);
    cmp("done_holds inst0", 32'({done0, out0}), 32'h120);

    // WIDTH=16 DIGIT=4 with en toggled and operands scrambled during ADD
    issue(1, 16'h1234, 16'h0FCD, 1'b0, 1'b1, 16'h2201, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      en1 = (i != 1); a1 = 16'hFFFF; b1 = 16'hFFFF; sub1 = 1'b1;
      @(posedge clk);
      #1;
    end
    en1 = 1'b0;
    wait_idle(1);

    // Back-to-back on WIDTH=8 DIGIT=2: en held, second operands presented during the first ADD
    en2 = 1'b1; a2 = 8'd3; b2 = 8'd4; sub2 = 1'b0;
    @(posedge clk);
    #1;
    e = '{out: 16'd7, cout: 1'b0, ovf: 1'b0, start_cyc: cyc, n: 4};
    sb2.push_back(e);
    a2 = 8'd10; b2 = 8'd1; sub2 = 1'b1;
    e = '{out: 16'd9, cout: 1'b1, ovf: 1'b0, start_cyc: cyc + 5, n: 4};
    sb2.push_back(e);
    repeat (4) @(posedge clk);
    #1;
    cmp("b2b_done_first inst2", 32'({busy2, done2}), 32'h1);
    @(posedge clk);
    #1;
    en2 = 1'b0;
    cmp("b2b_done_one_cycle inst2", 32'({busy2, done2}), 32'h2);
    wait_idle(2);

    wait_idle(0);
    wait_idle(1);
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/add_serial_param.md
# add_serial_param

Parametrised bit/digit-serial adder/subtractor, the successor to the fixed 8-bit, 1-bit-per-cycle serial adder. It processes WIDTH-bit operands DIGIT bits per cycle, LSB-first, and supports add and subtract modes. It provides carry-out and a done/busy handshake, and results can be issued back-to-back. It sits in the same datapath slot as the fixed serial adder, where area matters more than latency.

## Interface
- WIDTH, 8: operand and result width in bits; must be ≥ 2.
- DIGIT, 1: bits processed per cycle; must divide WIDTH exactly. Legal values are 1 to WIDTH.
- clk  in  1  rising-edge clock.
- rst  in  1  reset: asynchronous assert, active-low (0 = reset). It is released synchronously by the system.
- en  in  1  start request. Sampled only in IDLE and DONE.
- sub  in  1  mode, captured with the operands: 0 = a+b, 1 = a−b.
- a  in  WIDTH  operand A, captured on start.
- b  in  WIDTH  operand B, captured on start.
- out  out  WIDTH  result. Valid while done=1.
- cout  out  1  final carry. In subtract mode, cout=1 means no borrow (a ≥ b unsigned).
- ovf  out  1  signed overflow flag. Its behaviour is set under Configuration.
- busy  out  1  high in ADD.
- done  out  1  high in DONE.

## Operation
- N = WIDTH/DIGIT cycles per operation. The count register is clog2(N)+1 bits wide.
- States: IDLE, ADD, DONE. Encoding is free; illegal encodings go to IDLE.
- IDLE → ADD when en=1. The same start action applies:
  - a_reg=a
  - b_reg = sub ? ~b : b
  - carry=sub
  - count=0
  - out=0
  - mode register=sub
- IDLE stays IDLE when en=0.
- ADD, every cycle:
  - {c, s} = a_reg[DIGIT-1:0] + b_reg[DIGIT-1:0] + carry, computed DIGIT+1 bits wide.
  - out <= {s, out[WIDTH-1:DIGIT]}.
  - a_reg and b_reg shift right by DIGIT bits, zero-filled.
  - carry <= c.
  - count++.
- ADD → DONE on the cycle where count == N−1. That cycle's update completes the result.
- en during ADD is ignored. Operands and mode are not re-sampled.
- DONE: out, cout and ovf hold.
  - en=1 performs the start action and goes to ADD (back-to-back issue). done drops the next cycle.
  - en=0 stays in DONE.
- Results are modulo 2^WIDTH. cout = carry after the last digit.
- Reset (any time, including mid-operation):
  - state=IDLE
  - out=0, cout=0, ovf=0
  - busy=0, done=0
  - all internal registers 0
- No partial result survives reset.

## Timing
- Start accepted on edge T (en=1 in IDLE/DONE). busy=1 from T+1 through T+N.
- done=1 from T+N+1 until the cycle after the next accepted start.
- out, cout and ovf are final and stable from T+N+1.
- Latency from start edge to done: N+1 edges.
  - WIDTH=8, DIGIT=1: 9 edges.
  - WIDTH=8, DIGIT=4: 3 edges.
- Throughput: one operation per N+1 cycles with en held high.
- All outputs are registered. There are no combinational input-to-output paths.
- out is 0 during ADD's first cycle after start. It is a partial shift during ADD and must not be consumed while busy=1.

## Configuration
- Macro ADD_SERIAL_OVF_EN.
- Defined:
  - In the final ADD cycle, ovf <= (a_msb == b_msb_eff) && (s_msb != a_msb).
  - b_msb_eff is the bit of the inverted operand in subtract mode.
  - The a/b MSBs are sampled from a_reg/b_reg at that cycle, i.e. bit DIGIT-1 of the final digit.
  - ovf is cleared on start and held through DONE.
- Undefined: the overflow logic is absent and ovf is tied to constant 0. The port remains so integration is identical.

## Test plan
- Reset mid-ADD: start 8'h55+8'h0F, pull rst low at T+3 → all outputs 0 and state IDLE immediately. After release, no done until a new en.
- WIDTH=8, DIGIT=1, add: a=8'hFF, b=8'h01, sub=0 → out=8'h00, cout=1. done rises at T+9. busy is high for exactly 8 cycles.
- WIDTH=8, DIGIT=1, subtract: a=8'h05, b=8'h07, sub=1 → out=8'hFE, cout=0. With a=8'h07, b=8'h05 → out=8'h02, cout=1.
- WIDTH=16, DIGIT=4: a=16'h1234, b=16'h0FCD, sub=0 → out=16'h2201, cout=0, done at T+5. en toggled during ADD has no effect.
- Back-to-back: en held high through two operations (3+4, then 10−1, WIDTH=8, DIGIT=2) → out=7 then 9. Each done lasts exactly one cycle before the next busy. Operands change only at accepted starts.
- Overflow, with ADD_SERIAL_OVF_EN: 8'h7F+8'h01 → ovf=1; 8'h80−8'h01 → ovf=1; 8'h10+8'h10 → ovf=0. Without the macro, ovf=0 in all three cases.
